// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcode mnemonics, FSM states and opcode helpers.
package seq_alu_pkg;

    localparam int OP_W = 4;

    // Codes 0-7 match the legacy 3-bit combinational ALU encodings.
    typedef enum logic [OP_W-1:0] {
        kADD = 4'd0,
        kOR  = 4'd1,
        kXOR = 4'd2,
        kAND = 4'd3,
        kLT  = 4'd4,
        kEQ  = 4'd5,
        kSLL = 4'd6,
        kSRL = 4'd7,
        kSUB = 4'd8,
        kSRA = 4'd9,
        kMUL = 4'd10
    } op_mne;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } alu_state_t;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == kSLL) || (op == kSRL) || (op == kSRA);
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, low WIDTH bits kept.
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Asserted during the last iteration so the caller leaves its wait state in step.
    assign done_o    = (cnt_q == CW'(1));
    assign product_o = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Clocked valid/ready ALU with iterative shifts and flags.
// Define SEQ_ALU_MUL_EN to compile in the iterative multiplier (opcode 10); otherwise opcode 10 is reserved.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [OP_W-1:0]  OP,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    output logic             OutValid,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Neg
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    op_mne            op_view;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] res_w;
    logic             res_carry_w;
    logic [WIDTH-1:0] shifted_w;

    assign op_view = op_mne'(op_q);

`ifdef SEQ_ALU_MUL_EN
    logic             mul_start_w;
    logic             mul_done_w;
    logic [WIDTH-1:0] product_w;

    seq_alu_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .start_i  (mul_start_w),
        .a_i      (InputA),
        .b_i      (InputB),
        .done_o   (mul_done_w),
        .product_o(product_w)
    );
`endif

    // Result mux; shifts have already been applied to a_q in place.
    always_comb begin
        sum_w       = {1'b0, a_q} + {1'b0, b_q};
        diff_w      = {1'b0, a_q} - {1'b0, b_q};
        res_w       = '0;
        res_carry_w = 1'b0;
        case (op_view)
            kADD: begin
                res_w       = sum_w[WIDTH-1:0];
                res_carry_w = sum_w[WIDTH];
            end
            kSUB: begin
                res_w       = diff_w[WIDTH-1:0];
                res_carry_w = ~diff_w[WIDTH];
            end
            kOR:  res_w = a_q | b_q;
            kXOR: res_w = a_q ^ b_q;
            kAND: res_w = a_q & b_q;
            kLT:  res_w = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            kEQ:  res_w = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
            kSLL, kSRL, kSRA: res_w = a_q;
`ifdef SEQ_ALU_MUL_EN
            kMUL: res_w = product_w;
`endif
            default: res_w = '0;
        endcase
    end

    always_comb begin
        shifted_w = a_q;
        case (op_view)
            kSLL:    shifted_w = {a_q[WIDTH-2:0], 1'b0};
            kSRL:    shifted_w = {1'b0, a_q[WIDTH-1:1]};
            kSRA:    shifted_w = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            default: shifted_w = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        carry_d = carry_q;
        valid_d = 1'b0;
`ifdef SEQ_ALU_MUL_EN
        mul_start_w = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    op_d = OP;
                    a_d  = InputA;
                    b_d  = InputB;
                    if (is_shift(OP) && (InputB[SHW-1:0] != '0)) begin
                        state_d = SHIFT;
                        cnt_d   = InputB[SHW-1:0];
`ifdef SEQ_ALU_MUL_EN
                    end else if (OP == kMUL) begin
                        state_d     = MUL;
                        mul_start_w = 1'b1;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                a_d   = shifted_w;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            MUL: begin
                if (mul_done_w) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                out_d   = res_w;
                carry_d = res_carry_w;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    // Zero and Neg follow Out, which only changes alongside OutValid.
    assign InReady  = (state_q == IDLE);
    assign OutValid = valid_q;
    assign Out      = out_q;
    assign Carry    = carry_q;
    assign Zero     = (out_q == '0);
    assign Neg      = out_q[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu with a per-cycle reference model; latency counts the accept edge as edge 1.
module tb_seq_alu;

    localparam int W = 8;

    logic         Clk;
    logic         Reset;
    logic         InValid;
    logic         InReady;
    logic [3:0]   OP;
    logic [W-1:0] InputA;
    logic [W-1:0] InputB;
    logic         OutValid;
    logic [W-1:0] Out;
    logic         Zero;
    logic         Carry;
    logic         Neg;

    seq_alu #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .InValid (InValid),
        .InReady (InReady),
        .OP      (OP),
        .InputA  (InputA),
        .InputB  (InputB),
        .OutValid(OutValid),
        .Out     (Out),
        .Zero    (Zero),
        .Carry   (Carry),
        .Neg     (Neg)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    typedef struct {
        int           due;
        logic [W-1:0] out;
        logic         carry;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] held_out = '0;
    logic         held_c   = 1'b0;
    int           busy_until = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: result, carry and latency in edges (accept edge included).
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic c, output int lat);
        int unsigned ua = a;
        int unsigned ub = b;
        int          n  = int'(b) % W;
        r   = '0;
        c   = 1'b0;
        lat = 2;
        case (op)
            4'd0: begin r = W'(ua + ub); c = 1'((ua + ub) >> W); end
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = a & b;
            4'd4: r = (ua < ub) ? W'(1) : W'(0);
            4'd5: r = (ua == ub) ? W'(1) : W'(0);
            4'd6: begin r = W'(ua << n); lat = n + 2; end
            4'd7: begin r = W'(ua >> n); lat = n + 2; end
            4'd8: begin r = W'(ua - ub); c = (ua >= ub); end
            4'd9: begin r = W'($signed(a) >>> n); lat = n + 2; end
`ifdef SEQ_ALU_MUL_EN
            4'd10: begin r = W'(ua * ub); lat = W + 2; end
`endif
            default: r = '0;
        endcase
    endfunction

    // Per-cycle compare process.
    initial begin
        logic         exp_valid;
        logic         exp_ready;
        logic [W-1:0] r;
        logic         c;
        int           lat;
        forever begin
            @(negedge Clk);
            exp_valid = 1'b0;
            if (Reset) begin
                exp_q.delete();
                held_out   = '0;
                held_c     = 1'b0;
                busy_until = 0;
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_valid = (exp_q[0].due == cyc);
                held_out  = exp_q[0].out;
                held_c    = exp_q[0].carry;
                void'(exp_q.pop_front());
            end
            exp_ready = (cyc >= busy_until);
            check("in_ready",  InReady,  exp_ready);
            check("out_valid", OutValid, exp_valid);
            check("out",       Out,      held_out);
            check("carry",     Carry,    held_c);
            check("zero",      Zero,     held_out == '0);
            check("neg",       Neg,      held_out[W-1]);
            if (!Reset && InValid && exp_ready) begin
                model(OP, InputA, InputB, r, c, lat);
                exp_q.push_back('{cyc + lat, r, c});
                busy_until = cyc + lat;
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, output int edges, output logic [W-1:0] o,
                         output logic c, output logic z, output logic n);
        int   tries = 0;
        logic got   = 1'b0;
        edges = 0;
        o = '0; c = 1'b0; z = 1'b0; n = 1'b0;
        @(posedge Clk); #1;
        while (!InReady && tries < 200) begin
            @(posedge Clk); #1;
            tries++;
        end
        check("ready_wait", InReady, 1);
        InValid = 1'b1; OP = op; InputA = a; InputB = b;
        while (!got && edges < 200) begin
            @(posedge Clk); #1;
            edges++;
            if (edges <= hold) begin
                OP = 4'($urandom); InputA = W'($urandom); InputB = W'($urandom);
            end else begin
                InValid = 1'b0;
            end
            @(negedge Clk);
            if (OutValid) begin
                got = 1'b1; o = Out; c = Carry; z = Zero; n = Neg;
            end
        end
        InValid = 1'b0;
        check("done_wait", got, 1);
        $display("op=%0d a=0x%02h b=0x%02h -> out=0x%02h c=%0b z=%0b n=%0b edges=%0d",
                 op, a, b, o, c, z, n, edges);
    endtask

    initial begin
        int           e;
        logic [W-1:0] o;
        logic         c, z, n;
        logic         seen;

        Reset = 1'b1; InValid = 1'b0; OP = '0; InputA = '0; InputB = '0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("rst_ready", InReady, 1);
        check("rst_zero",  Zero,    1);
        check("rst_out",   Out,     0);

        do_op(4'd0, 8'hF0, 8'h20, 0, e, o, c, z, n);
        check("add_edges", e, 2); check("add_out", o, 8'h10);
        check("add_c", c, 1); check("add_z", z, 0); check("add_n", n, 0);

        do_op(4'd8, 8'h05, 8'h05, 0, e, o, c, z, n);
        check("sub0_out", o, 8'h00); check("sub0_z", z, 1); check("sub0_c", c, 1);
        do_op(4'd8, 8'h03, 8'h04, 0, e, o, c, z, n);
        check("sub1_out", o, 8'hFF); check("sub1_c", c, 0); check("sub1_n", n, 1);

        do_op(4'd9, 8'h80, 8'd3, 2, e, o, c, z, n);
        check("sra_edges", e, 5); check("sra_out", o, 8'hF0);
        do_op(4'd7, 8'h80, 8'd3, 0, e, o, c, z, n);
        check("srl_edges", e, 5); check("srl_out", o, 8'h10);
        do_op(4'd6, 8'h81, 8'd9, 0, e, o, c, z, n);
        check("sll_mask_edges", e, 3); check("sll_mask_out", o, 8'h02);
        do_op(4'd6, 8'h81, 8'd8, 0, e, o, c, z, n);
        check("sll0_edges", e, 2); check("sll0_out", o, 8'h81);

        do_op(4'd10, 8'd13, 8'd11, 0, e, o, c, z, n);
`ifdef SEQ_ALU_MUL_EN
        check("mul_edges", e, 10); check("mul_out", o, 8'h8F);
`else
        check("mul_edges", e, 2); check("mul_out", o, 8'h00); check("mul_z", z, 1);
`endif
        do_op(4'd12, 8'hAA, 8'h55, 0, e, o, c, z, n);
        check("rsv_edges", e, 2); check("rsv_out", o, 8'h00); check("rsv_z", z, 1);
        do_op(4'd6, 8'h81, 8'd0, 0, e, o, c, z, n);

        // Reset a few cycles into a multiply-length operation.
        @(posedge Clk); #1;
        InValid = 1'b1; OP = 4'd10; InputA = 8'd13; InputB = 8'd11;
        @(posedge Clk); #1;
        InValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        check("midrst_out",   Out,      0);
        check("midrst_zero",  Zero,     1);
        check("midrst_neg",   Neg,      0);
        check("midrst_ready", InReady,  1);
        check("midrst_valid", OutValid, 0);
        @(posedge Clk); @(posedge Clk); #1 Reset = 1'b0;
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge Clk);
            seen |= OutValid;
        end
        check("midrst_no_valid", seen, 0);

        // Reset together with InValid: nothing accepted.
        @(posedge Clk); #1;
        Reset = 1'b1; InValid = 1'b1; OP = 4'd0; InputA = 8'd1; InputB = 8'd1;
        @(posedge Clk); #1;
        Reset = 1'b0; InValid = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            seen |= OutValid;
        end
        check("rst_inv_no_valid", seen, 0);

        do_op(4'd5, 8'd7, 8'd7, 0, e, o, c, z, n);
        check("eq_edges", e, 2); check("eq_out", o, 8'h01);

        for (int i = 0; i < 300; i++) begin
            do_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                  int'($urandom_range(0, 1)), e, o, c, z, n);
        end

        repeat (W + 4) @(posedge Clk);
        @(negedge Clk);
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

- Parametrised, clocked successor to the combinational datapath ALU.
- Registers its operands and result, adds SUB, arithmetic shift right and an iterative multiply, and raises Zero/Carry/Neg flags.
- Moves data with a valid/ready handshake, so the core controller can issue a multi-cycle operation and stall until the result returns.
- Sits between the register file read ports and the write-back mux.

## Interface
- WIDTH, 8, datapath width; power of two, ≥ 4.
- SHW, $clog2(WIDTH), derived local parameter; shift-amount width.

- Clk  input  1  clock, all state on rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- InValid  input  1  operands and opcode present this cycle.
- InReady  output  1  block idle; an operation is accepted on any edge where InValid & InReady.
- OP  input  4  opcode (op_mne encoding).
- InputA  input  WIDTH  operand A.
- InputB  input  WIDTH  operand B; for shifts only InputB[SHW-1:0] is used.
- OutValid  output  1  one-cycle pulse; Out and flags are new this cycle.
- Out  output  WIDTH  result, held until the next OutValid.
- Zero  output  1  Out == 0.
- Carry  output  1  ADD carry-out / SUB no-borrow; 0 for all other ops.
- Neg  output  1  Out[WIDTH-1].

## Operation
- Opcodes:
  - 0 ADD, 1 OR, 2 XOR, 3 AND, 4 LT (unsigned, result zero-extended), 5 EQ (zero-extended), 6 SLL, 7 SRL, 8 SUB, 9 SRA, 10 MUL (low WIDTH bits, unsigned).
  - 0–7 keep the legacy 3-bit encodings.
  - 11–15 are reserved: Out = 0, Carry = 0, single-cycle.
- FSM states are IDLE, SHIFT, MUL and DONE.
- IDLE:
  - InReady = 1.
  - On accept, latch A, B and OP.
  - Single-cycle ops and any shift with amount 0 go to DONE.
  - Shifts with amount n > 0 go to SHIFT with counter = n.
  - MUL goes to MUL with counter = WIDTH.
- SHIFT:
  - Shift the working register one position per cycle: SLL fills 0, SRL fills 0, SRA replicates the sign bit.
  - Decrement the counter; go to DONE when it reaches 1.
- MUL:
  - Shift-add, one multiplier bit per cycle, LSB first.
  - After WIDTH iterations go to DONE.
- DONE:
  - Load Out and the flags, pulse OutValid, return to IDLE.
  - InReady is 0 in DONE.
- InValid while InReady = 0 is ignored, with no queueing.
- There is no output back-pressure; the consumer must capture on OutValid.
- Width rules:
  - ADD/SUB compute WIDTH+1 bits; Carry is bit WIDTH for ADD and the inverse borrow for SUB (A ≥ B gives 1).
  - All results are truncated to WIDTH bits.
- Flags are computed from the final Out and update only on OutValid.

## Timing
- Reset values: state IDLE, InReady 1, OutValid 0, Out 0, Zero 1, Carry 0, Neg 0.
- Latency is counted from the accepting edge to the edge on which OutValid rises:
  - single-cycle ops and zero shifts: 2 edges;
  - shift by n: n+2 edges;
  - MUL: WIDTH+2 edges.
- Back-to-back throughput: a new op can be accepted on the edge after OutValid.
- Reset mid-operation:
  - the operation is abandoned;
  - no OutValid is produced;
  - outputs return to their reset values.
- Reset asserted in the same cycle as InValid: the operation is not accepted.
- A shift amount ≥ WIDTH cannot occur because of masking; with WIDTH = 8, InputB = 9 shifts by 1.

## Configuration
- SEQ_ALU_MUL_EN defined: the MUL state and the shift-add datapath are compiled in; opcode 10 behaves as specified above.
- SEQ_ALU_MUL_EN undefined: the MUL state and datapath are absent, and opcode 10 is treated as reserved (single-cycle, Out = 0, Zero = 1).

## Structure
- Shared package definitions holds:
  - the op_mne enum, widened to 4 bits, with kSUB, kSRA and kMUL added and the legacy values unchanged;
  - the alu_state_t enum (IDLE, SHIFT, MUL, DONE).
- The block drives an op_mne-cast signal for the waveform viewer.
- One sub-module, seq_alu_mul: the iterative shift-add multiplier with start/done.
  - It is instantiated only under SEQ_ALU_MUL_EN.
- Single-cycle ops and the shifter stay in seq_alu.

## Test plan
- Reset released, then ADD A=0xF0, B=0x20 (WIDTH=8):
  - OutValid 2 edges after accept;
  - Out=0x10, Carry=1, Zero=0, Neg=0.
- SUB A=0x05, B=0x05, then SUB A=0x03, B=0x04:
  - first gives Out=0x00, Zero=1, Carry=1;
  - second gives Out=0xFF, Carry=0, Neg=1.
- SRA A=0x80, B=3, then SRL with the same operands:
  - SRA gives Out=0xF0 after 5 edges;
  - SRL gives Out=0x10;
  - InValid pulsed mid-shift is ignored, with InReady=0 throughout.
- MUL A=13, B=11 with SEQ_ALU_MUL_EN: Out=0x8F after 10 edges.
- MUL without SEQ_ALU_MUL_EN: Out=0, Zero=1 after 2 edges.
- Reserved OP=12: Out=0, Zero=1 after 2 edges.
- Reset asserted 3 cycles into a MUL:
  - outputs are at reset values immediately;
  - no OutValid appears;
  - a following EQ A=7, B=7 gives Out=1.
